// File: rtl/muldiv_ctrl.sv
// Purpose: sequencer for an iterative RV32M multiply/divide unit beside EX, one bit per cycle.
// Latency: done in cycle XLEN+2 after start is accepted (cycle 1 for early-out cases when enabled).
// Backpressure: stall_req holds PC, IF/ID and ID/EX from acceptance until DONE; flush squashes the op.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             M-extension op valid in EX (level, held while stalled)
//   funct3            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a, op_b        rs1 / rs2 values
//   flush             squash any in-flight op (control hazard); wins over start
//   result            op result, valid with done and held until the next completion or rst
//   done              one-cycle completion pulse
//   busy              state is CALC or FIX
//   stall_req         pipeline hold request
//
// Optional feature: define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and
// multiply-by-zero directly from IDLE (done in cycle 1, stall_req only in cycle 0).

module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall_req
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   dividend_q;   // original rs1, needed for REM by zero
    logic [XLEN-1:0]   opnd_q;       // |multiplicand| or |divisor|
    logic [2*XLEN-1:0] acc;          // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
    logic              neg_a_q;
    logic              neg_b_q;
    logic              div0_q;
    logic              ovf_q;
    logic [CW-1:0]     cnt;

    // ---------------- operand decode at acceptance ----------------
    logic            is_div_in;
    logic            sgn_a_in;
    logic            sgn_b_in;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [XLEN-1:0] a_abs_in;
    logic [XLEN-1:0] b_abs_in;
    logic            div0_in;
    logic            ovf_in;

    always_comb begin
        is_div_in = funct3[2];
        sgn_a_in  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_in  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a_in  = sgn_a_in && op_a[XLEN-1];
        neg_b_in  = sgn_b_in && op_b[XLEN-1];
        a_abs_in  = neg_a_in ? -op_a : op_a;
        b_abs_in  = neg_b_in ? -op_b : op_b;
        div0_in   = (op_b == '0);
        // sgn_b_in together with funct3[2] selects exactly DIV and REM
        ovf_in    = sgn_b_in && funct3[2] && (op_a == MOST_NEG) && (op_b == '1);
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN:0]     div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // shift-add: add multiplicand into the high half when the current multiplier bit is set,
        // then shift the whole product right; the carry lands in the top bit
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // restoring divide: bring in the next dividend bit, subtract the divisor if it fits
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_rem  = div_sh - (div_ge ? {1'b0, opnd_q} : '0);
        div_next = {div_rem[XLEN-1:0], acc[XLEN-2:0], div_ge};
    end

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo_s  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:          fix_val = prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fix_val = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fix_val = div0_q ? '1 : (ovf_q ? MOST_NEG : quo_s);
            default:         fix_val = div0_q ? dividend_q : (ovf_q ? '0 : rem_s);
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_val;

    always_comb begin
        if (is_div_in) begin
            early_hit = div0_in || ovf_in;
            if (funct3[1]) early_val = div0_in ? op_a : '0;       // REM/REMU
            else           early_val = div0_in ? '1 : MOST_NEG;   // DIV/DIVU
        end else begin
            early_hit = (op_a == '0) || (op_b == '0);
            early_val = '0;
        end
    end
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            f3_q       <= '0;
            dividend_q <= '0;
            opnd_q     <= '0;
            acc        <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            f3_q       <= funct3;
                            dividend_q <= op_a;
                            neg_a_q    <= neg_a_in;
                            neg_b_q    <= neg_b_in;
                            div0_q     <= div0_in;
                            ovf_q      <= ovf_in;
                            cnt        <= '0;
                            if (is_div_in) begin
                                opnd_q <= b_abs_in;
                                acc    <= {{XLEN{1'b0}}, a_abs_in};
                            end else begin
                                opnd_q <= a_abs_in;
                                acc    <= {{XLEN{1'b0}}, b_abs_in};
                            end
`ifdef MULDIV_EARLY_OUT_EN
                            if (early_hit) begin
                                state  <= DONE;
                                result <= early_val;
                                done   <= 1'b1;
                            end else begin
                                state <= CALC;
                                busy  <= 1'b1;
                            end
`else
                            state <= CALC;
                            busy  <= 1'b1;
`endif
                        end
                    end
                    CALC: begin
                        acc <= f3_q[2] ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                    default: begin
                        // start still belongs to the retiring instruction here
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Must cover the acceptance cycle too, so it cannot wait for the state register.
    assign stall_req = ((state == IDLE) && start && !flush) || (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall_req;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h with no op outstanding (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Issue one op, hold start through DONE, then drop it for one idle cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int   t0;
        int   lat;
        exp_t e;
        lat    = lat_of(f, a, b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        t0     = cyc;
        e.res  = ref_op(f, a, b);
        e.at   = t0 + lat;
        sb_q.push_back(e);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("stall_while_busy", {31'b0, stall_req}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("stall_in_done", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("no_second_done", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("result_hold", result, e.res);
        last_res = e.res;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed corner cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // flush a DIV in its cycle 10, then start MUL 3*4 in cycle 12
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_stall", {31'b0, stall_req}, 32'd0);
        check("flush_result", result, last_res);
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd4);

        // reset in the middle of CALC
        funct3 = 3'd1; op_a = $urandom; op_b = $urandom; start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_result", result, 32'h0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_stall", {31'b0, stall_req}, 32'd0);
        last_res = '0;
        @(posedge clk); #1;

        // randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 3'($urandom_range(0, 7));
            a = pick_opnd();
            b = pick_opnd();
            run_op(f, a, b);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
